// File: rtl/data_sram_bridge_pkg.sv
// Shared encodings for the data-SRAM to request/acknowledge bus bridge:
// FSM state codes, bus transfer sizes and the decoded request fields.
package data_sram_bridge_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    typedef struct packed {
        logic       wr;
        logic [1:0] size;
        logic [3:0] wstrb;
    } req_dec_t;

endpackage

// File: rtl/data_sram_size_dec.sv
// Combinational decode of the core byte-write strobes into bus direction,
// transfer size and byte strobes.
module data_sram_size_dec
    import data_sram_bridge_pkg::*;
(
    input  logic [3:0] wen,
    output req_dec_t   dec
);

    // Strobe pattern to size; unrecognised patterns go out as a word with raw strobes
    always_comb begin
        dec.wr    = (wen != 4'b0000);
        dec.wstrb = wen;
        dec.size  = MEM_SIZE_WORD;
        case (wen)
            4'b0011, 4'b1100:                   dec.size = MEM_SIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: dec.size = MEM_SIZE_BYTE;
            default:                            dec.size = MEM_SIZE_WORD;
        endcase
    end

endmodule

// File: rtl/data_sram_bridge.sv
// Converts the core's single-cycle data-SRAM request into a req/addr_ok,
// data_ok bus transaction, stalling the pipeline while it is in flight.
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter bit POST_WRITES = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        ex_stall,
    output logic        stallreq_from_mem,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    logic [1:0] state_r;
    logic       wr_pend_r;
    logic       stall_s;
    req_dec_t   dec_s;

    data_sram_size_dec u_size_dec (
        .wen (data_sram_wen),
        .dec (dec_s)
    );

    // Stall request: raised as soon as the core asks, dropped once the access is done
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: stall_s = data_sram_en;
            ST_REQ:  stall_s = 1'b1;
            ST_WAIT: stall_s = 1'b1;
            ST_DONE: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Reset forces the stall low immediately even though en may still be high
    assign stallreq_from_mem = stall_s & ~rst;

    // Transaction FSM, request register, read-data register and posted-write tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            wr_pend_r       <= 1'b0;
            mem_req         <= 1'b0;
            mem_wr          <= 1'b0;
            mem_size        <= 2'd0;
            mem_wstrb       <= 4'd0;
            mem_addr        <= 32'd0;
            mem_wdata       <= 32'd0;
            data_sram_rdata <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_data_ok) begin
                        wr_pend_r <= 1'b0;
                    end
                    // Nothing issues behind a posted write, so data_ok stays unambiguous
                    if (data_sram_en && !wr_pend_r) begin
                        state_r   <= ST_REQ;
                        mem_req   <= 1'b1;
                        mem_wr    <= dec_s.wr;
                        mem_size  <= dec_s.size;
                        mem_wstrb <= dec_s.wstrb;
                        mem_addr  <= data_sram_addr;
                        mem_wdata <= data_sram_wdata;
                    end
                end
                ST_REQ: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        if (mem_wr && POST_WRITES) begin
                            state_r   <= ST_DONE;
                            wr_pend_r <= ~mem_data_ok;
                        end else if (mem_data_ok) begin
                            if (!mem_wr) begin
                                data_sram_rdata <= mem_rdata;
                            end
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_data_ok) begin
                        if (!mem_wr) begin
                            data_sram_rdata <= mem_rdata;
                        end
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (mem_data_ok) begin
                        wr_pend_r <= 1'b0;
                    end
                    // EX still holds the same instruction with en high while stalled elsewhere
                    if (!ex_stall) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
